// File: rtl/bp_fe_parcel_buffer.sv
// Circular buffer of 16b instruction parcels feeding bp_fe_scan.
// Aligned fetch blocks come in; a window of up to fetch_cinstr_p parcels goes out.
module bp_fe_parcel_buffer #(
  parameter int vaddr_width_p  = 39,
  parameter int fetch_cinstr_p = 4,
  parameter int depth_p        = 8,
  localparam int ptr_w         = $clog2(fetch_cinstr_p+1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic                        fetch_v_i,
  output logic                        fetch_ready_o,
  input  logic [vaddr_width_p-1:0]    fetch_pc_i,
  input  logic [16*fetch_cinstr_p-1:0] fetch_data_i,
  output logic                        v_o,
  output logic [vaddr_width_p-1:0]    pc_o,
  output logic [16*fetch_cinstr_p-1:0] instr_o,
  output logic [ptr_w-1:0]            count_o,
  output logic [ptr_w-1:0]            partial_o,
  input  logic [ptr_w-1:0]            yumi_i
);

  localparam int idx_w = $clog2(depth_p);
  localparam int off_w = $clog2(fetch_cinstr_p);
  localparam int occ_w = idx_w + 1;
  localparam logic [occ_w-1:0] ready_max_lp = occ_w'(depth_p - fetch_cinstr_p);
  localparam logic [occ_w-1:0] fetch_lp     = occ_w'(fetch_cinstr_p);

  typedef enum logic {S_EMPTY, S_FILLED} state_e;

  state_e                   state_q, state_d;
  logic [idx_w-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [occ_w-1:0]         occ_q, occ_d;
  logic [vaddr_width_p-1:0] head_pc_q, head_pc_d;
  logic [15:0]              mem_q [depth_p];

  logic                     enq;
  logic [off_w-1:0]         off;
  logic [occ_w-1:0]         enq_cnt, enq_add, yumi_ext;
  logic [depth_p-1:0]       wr_en;
  logic [15:0]              wr_data [depth_p];
  logic [ptr_w-1:0]         count;
  logic                     partial;
  logic                     occ_nz;

  // Ready looks only at registered occupancy so it never depends on yumi_i.
  assign fetch_ready_o = (occ_q <= ready_max_lp);
  assign enq           = fetch_v_i & fetch_ready_o & ~flush_i;
  assign off           = fetch_pc_i[1 +: off_w];
  assign enq_cnt       = fetch_lp - occ_w'(off);
  assign enq_add       = enq ? enq_cnt : '0;
  assign yumi_ext      = occ_w'(yumi_i);

  // Each storage slot picks its source parcel by its distance from wr_ptr.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < depth_p; j++) begin
      wr_data[j] = '0;
    end
    for (int j = 0; j < depth_p; j++) begin
      wr_en[j]   = enq && ({1'b0, idx_w'(j) - wr_ptr_q} < enq_cnt);
      wr_data[j] = fetch_data_i[16*(off + off_w'(idx_w'(j) - wr_ptr_q)) +: 16];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < depth_p; j++) begin
      if (wr_en[j]) mem_q[j] <= wr_data[j];
    end
  end

  always_comb begin
    occ_nz  = (occ_q != '0);
    count   = (occ_q >= fetch_lp) ? ptr_w'(fetch_cinstr_p) : ptr_w'(occ_q);
    partial = (occ_q == occ_w'(1)) && (mem_q[rd_ptr_q][1:0] == 2'b11);
    instr_o = '0;
    for (int k = 0; k < fetch_cinstr_p; k++) begin
      instr_o[16*k +: 16] = (ptr_w'(k) < count) ? mem_q[rd_ptr_q + idx_w'(k)] : 16'h0;
    end
    v_o       = occ_nz & ~partial;
    count_o   = count;
    partial_o = {{(ptr_w-1){1'b0}}, partial};
    pc_o      = occ_nz ? head_pc_q : '0;
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    head_pc_d = head_pc_q;
    if (flush_i) begin
      occ_d    = '0;
      rd_ptr_d = wr_ptr_q;
      state_d  = S_EMPTY;
    end else begin
      rd_ptr_d = rd_ptr_q + idx_w'(yumi_i);
      wr_ptr_d = wr_ptr_q + idx_w'(enq_add);
      occ_d    = occ_q + enq_add - yumi_ext;
      if (state_q == S_EMPTY && enq) begin
        head_pc_d = fetch_pc_i;
      end else begin
        head_pc_d = head_pc_q + vaddr_width_p'({yumi_i, 1'b0});
      end
      state_d = (occ_d != '0) ? S_FILLED : S_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_EMPTY;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      head_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      head_pc_q <= head_pc_d;
    end
  end

  // Protocol checks on the consumer and on fetch-stream contiguity.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !flush_i) begin
      assert (yumi_i <= count)
        else $error("parcel_buffer: yumi_i %0d exceeds count_o %0d", yumi_i, count);
      assert (yumi_i == '0 || v_o)
        else $error("parcel_buffer: yumi_i %0d while v_o low", yumi_i);
      assert (!(enq && state_q == S_FILLED) ||
              fetch_pc_i == head_pc_q + vaddr_width_p'({occ_q, 1'b0}))
        else $error("parcel_buffer: fetch pc %0h not contiguous", fetch_pc_i);
    end
  end

endmodule
